vref_sweep_cal_rx: RTL and testbench

//  RX-side reference-voltage calibration for MBTRAIN, parametrised in lane count and vref width.

---
 rtl/vref_sweep_cal_rx.sv | 262 ++++++++++++++++++++++++++
 tb/tb_vref_sweep_cal_rx.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vref_sweep_cal_rx.sv
// ----------------------------------------------------------------------------
// vref_sweep_cal_rx
//
// RX-side reference-voltage calibration for MBTRAIN. After the partner die
// sends a start request (and receives our start response), the block sweeps
// the receiver vref code from VREF_MIN to VREF_MAX. Each code is followed by
// a settle period and one point test. The block then picks the centre of the
// widest window in which every lane passed, and finishes with the end
// request/response exchange.
//
// Optional feature: define VREF_SWEEP_LOG_EN to add o_pass_map. Bit k of
// o_pass_map holds the pass result of code k.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_en                        block enable; dropping it aborts to IDLE
//   i_decoded_sideband_message  4'b0001 start req, 4'b0011 end req
//   i_sideband_valid            qualifies i_decoded_sideband_message
//   i_busy_negedge_detected     sideband serializer finished our message
//   i_valid_tx                  TX block owns the sideband mux this cycle
//   i_pt_done                   point test finished (1-cycle pulse)
//   i_rx_lanes_result           per-lane pass flags, valid with i_pt_done
//   o_sideband_message          4'b0010 start resp, 4'b0100 end resp, else 0
//   o_valid_rx                  send request for o_sideband_message
//   o_pt_en                     point test enable
//   o_reciever_ref_voltage      vref control word
//   o_best_window               length of the chosen pass window (0 = none)
//   o_cal_fail                  no code passed on all lanes
//   o_test_ack                  calibration and end handshake complete
//   o_pass_map                  (VREF_SWEEP_LOG_EN only) per-code pass log
//   dbg_state                   current FSM state, for debug/checkers
//
// Sideband handshake: a send request sets a pending flag. o_valid_rx rises
// once the flag is set and the TX block does not own the mux. The serializer
// busy falling edge then clears both o_valid_rx and the flag. That clear wins
// over a new request arriving in the same cycle.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module vref_sweep_cal_rx #(
   parameter int NUM_LANES    = 16,
   parameter int VREF_W       = 4,
   parameter int VREF_MIN     = 0,
   parameter int VREF_MAX     = 15,
   parameter int VREF_DEFAULT = 8,
   parameter int SETTLE_CYC   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_en,
   input  logic [3:0]           i_decoded_sideband_message,
   input  logic                 i_sideband_valid,
   input  logic                 i_busy_negedge_detected,
   input  logic                 i_valid_tx,
   input  logic                 i_pt_done,
   input  logic [NUM_LANES-1:0] i_rx_lanes_result,
   output logic [3:0]           o_sideband_message,
   output logic                 o_valid_rx,
   output logic                 o_pt_en,
   output logic [VREF_W-1:0]    o_reciever_ref_voltage,
   output logic [VREF_W:0]      o_best_window,
   output logic                 o_cal_fail,
   output logic                 o_test_ack,
`ifdef VREF_SWEEP_LOG_EN
   output logic [2**VREF_W-1:0] o_pass_map,
`endif
   output logic [2:0]           dbg_state
);

   localparam int CNT_W = $clog2(SETTLE_CYC + 1);
   localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(SETTLE_CYC);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [VREF_W-1:0] MIN_C    = VREF_W'(VREF_MIN);
   localparam logic [VREF_W-1:0] MAX_C    = VREF_W'(VREF_MAX);
   localparam logic [VREF_W-1:0] DEF_C    = VREF_W'(VREF_DEFAULT);
   localparam logic [VREF_W:0]   LEN_ONE  = (VREF_W+1)'(1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT_START = 3'd1,
      S_SETTLE     = 3'd2,
      S_POINT_TEST = 3'd3,
      S_EVAL       = 3'd4,
      S_WAIT_END   = 3'd5,
      S_SEND_END   = 3'd6,
      S_DONE       = 3'd7
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  settle_cnt;
   logic              pass_q;
   logic              end_pending;
   logic              send_pending;
   logic              valid_d;
   logic [VREF_W-1:0] run_start, best_start;
   logic [VREF_W:0]   run_len, best_len;

   logic              is_start, is_end, valid_fall, take_cur;
   logic [VREF_W:0]   cur_len, fin_len, centre;
   logic [VREF_W-1:0] cur_start, fin_start;

   assign dbg_state = state;

   always_comb begin
      is_start   = i_sideband_valid && (i_decoded_sideband_message == 4'b0001);
      is_end     = i_sideband_valid && (i_decoded_sideband_message == 4'b0011);
      valid_fall = valid_d && !o_valid_rx;
      // The current run, extended by this code's result. A run that starts
      // here begins at the current code.
      cur_len    = pass_q ? (run_len + LEN_ONE) : '0;
      cur_start  = (run_len == '0) ? o_reciever_ref_voltage : run_start;
      // Best is updated as soon as a run grows strictly past it. Ties
      // therefore keep the earlier (lower) window, and the final answer
      // matches comparing each closed run against the best.
      take_cur   = pass_q && (cur_len > best_len);
      fin_len    = take_cur ? cur_len : best_len;
      fin_start  = take_cur ? cur_start : best_start;
      // Floor centre, computed one bit wider so VREF_MAX = 2**VREF_W-1 cannot wrap.
      centre     = {1'b0, fin_start} + ((fin_len - LEN_ONE) >> 1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                  <= S_IDLE;
         settle_cnt             <= '0;
         pass_q                 <= 1'b0;
         end_pending            <= 1'b0;
         send_pending           <= 1'b0;
         valid_d                <= 1'b0;
         run_start              <= '0;
         run_len                <= '0;
         best_start             <= '0;
         best_len               <= '0;
         o_sideband_message     <= 4'b0000;
         o_valid_rx             <= 1'b0;
         o_pt_en                <= 1'b0;
         o_reciever_ref_voltage <= DEF_C;
         o_best_window          <= '0;
         o_cal_fail             <= 1'b0;
         o_test_ack             <= 1'b0;
`ifdef VREF_SWEEP_LOG_EN
         o_pass_map             <= '0;
`endif
      end else begin
         valid_d <= o_valid_rx;
         case (state)
            S_IDLE: begin
               if (i_en) begin
                  state              <= S_WAIT_START;
                  o_test_ack         <= 1'b0;
                  o_cal_fail         <= 1'b0;
                  o_best_window      <= '0;
                  o_sideband_message <= 4'b0000;
                  run_start          <= '0;
                  run_len            <= '0;
                  best_start         <= '0;
                  best_len           <= '0;
                  end_pending        <= 1'b0;
`ifdef VREF_SWEEP_LOG_EN
                  o_pass_map         <= '0;
`endif
               end
            end
            S_WAIT_START: begin
               if (is_start) begin
                  o_sideband_message     <= 4'b0010;
                  send_pending           <= 1'b1;
                  o_reciever_ref_voltage <= MIN_C;
                  settle_cnt             <= CNT_INIT;
                  state                  <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (is_end) end_pending <= 1'b1;
               if (settle_cnt == CNT_ONE) begin
                  o_pt_en <= 1'b1;
                  state   <= S_POINT_TEST;
               end else begin
                  settle_cnt <= settle_cnt - CNT_ONE;
               end
            end
            S_POINT_TEST: begin
               if (is_end) end_pending <= 1'b1;
               if (i_pt_done) begin
                  pass_q  <= &i_rx_lanes_result;
                  o_pt_en <= 1'b0;
                  state   <= S_EVAL;
               end
            end
            S_EVAL: begin
               run_len <= cur_len;
               if (pass_q) run_start <= cur_start;
               if (take_cur) begin
                  best_len   <= cur_len;
                  best_start <= cur_start;
               end
`ifdef VREF_SWEEP_LOG_EN
               o_pass_map[o_reciever_ref_voltage] <= pass_q;
`endif
               if (o_reciever_ref_voltage != MAX_C) begin
                  if (is_end) end_pending <= 1'b1;
                  o_reciever_ref_voltage <= o_reciever_ref_voltage + 1'b1;
                  settle_cnt             <= CNT_INIT;
                  state                  <= S_SETTLE;
               end else begin
                  if (fin_len != '0) begin
                     o_reciever_ref_voltage <= centre[VREF_W-1:0];
                     o_best_window          <= fin_len;
                  end else begin
                     o_reciever_ref_voltage <= DEF_C;
                     o_cal_fail             <= 1'b1;
                  end
                  // An end request seen during the sweep is answered right away.
                  if (end_pending || is_end) begin
                     o_sideband_message <= 4'b0100;
                     send_pending       <= 1'b1;
                     end_pending        <= 1'b0;
                     state              <= S_SEND_END;
                  end else begin
                     state <= S_WAIT_END;
                  end
               end
            end
            S_WAIT_END: begin
               if (is_end || end_pending) begin
                  o_sideband_message <= 4'b0100;
                  send_pending       <= 1'b1;
                  end_pending        <= 1'b0;
                  state              <= S_SEND_END;
               end
            end
            S_SEND_END: begin
               if (valid_fall) begin
                  o_sideband_message <= 4'b0000;
                  o_test_ack         <= 1'b1;
                  state              <= S_DONE;
               end
            end
            S_DONE: begin
            end
            default: state <= S_IDLE;
         endcase

         // Sideband send handshake; the busy clear overrides any set above.
         if (i_busy_negedge_detected) begin
            o_valid_rx   <= 1'b0;
            send_pending <= 1'b0;
         end else if (send_pending && !i_valid_tx) begin
            o_valid_rx <= 1'b1;
         end

         // Dropping enable abandons the run; vref keeps its current value.
         if (!i_en && state != S_IDLE) begin
            state              <= S_IDLE;
            o_pt_en            <= 1'b0;
            o_valid_rx         <= 1'b0;
            send_pending       <= 1'b0;
            o_sideband_message <= 4'b0000;
         end
      end
   end

endmodule

// File: tb/tb_vref_sweep_cal_rx.sv
// ----------------------------------------------------------------------------
// tb_vref_sweep_cal_rx
//
// Bench for vref_sweep_cal_rx with 16 lanes, a 4-bit vref, sweep 0..15 and
// default code 8. The bench plays the partner die and the point-test engine.
// Per-code pass patterns are random or directed. Expected results come from
// a window-search model that scans the pass pattern for runs of passing
// codes.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vref_sweep_cal_rx;
   localparam int NL = 16;
   localparam int VW = 4;
   localparam logic [2:0] ST_IDLE = 3'd0;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_en = 1'b0;
   logic [3:0]    i_decoded_sideband_message = '0;
   logic          i_sideband_valid = 1'b0;
   logic          i_busy_negedge_detected = 1'b0;
   logic          i_valid_tx = 1'b0;
   logic          i_pt_done = 1'b0;
   logic [NL-1:0] i_rx_lanes_result = '0;
   logic [3:0]    o_sideband_message;
   logic          o_valid_rx;
   logic          o_pt_en;
   logic [VW-1:0] o_reciever_ref_voltage;
   logic [VW:0]   o_best_window;
   logic          o_cal_fail;
   logic          o_test_ack;
   logic [2:0]    dbg_state;
`ifdef VREF_SWEEP_LOG_EN
   logic [2**VW-1:0] o_pass_map;
`endif

   int tests_run = 0;
   int tests_failed = 0;
   logic [VW-1:0] exp_q[$];

   vref_sweep_cal_rx #(
      .NUM_LANES(NL), .VREF_W(VW), .VREF_MIN(0), .VREF_MAX(15),
      .VREF_DEFAULT(8), .SETTLE_CYC(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_en(i_en),
      .i_decoded_sideband_message(i_decoded_sideband_message),
      .i_sideband_valid(i_sideband_valid),
      .i_busy_negedge_detected(i_busy_negedge_detected),
      .i_valid_tx(i_valid_tx), .i_pt_done(i_pt_done),
      .i_rx_lanes_result(i_rx_lanes_result),
      .o_sideband_message(o_sideband_message), .o_valid_rx(o_valid_rx),
      .o_pt_en(o_pt_en), .o_reciever_ref_voltage(o_reciever_ref_voltage),
      .o_best_window(o_best_window), .o_cal_fail(o_cal_fail),
      .o_test_ack(o_test_ack),
`ifdef VREF_SWEEP_LOG_EN
      .o_pass_map(o_pass_map),
`endif
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic send_sb(input logic [3:0] msg);
      i_sideband_valid = 1'b1;
      i_decoded_sideband_message = msg;
      tick();
      i_sideband_valid = 1'b0;
      i_decoded_sideband_message = '0;
   endtask

   task automatic pulse_busy();
      i_busy_negedge_detected = 1'b1;
      tick();
      i_busy_negedge_detected = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (o_valid_rx === 1'b1) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   task automatic wait_pt_en(input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (o_pt_en === 1'b1) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   task automatic wait_ack(input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (o_test_ack === 1'b1) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   function automatic logic [NL-1:0] fail_lanes();
      logic [NL-1:0] v;
      v = NL'($urandom);
      v[$urandom_range(0, NL-1)] = 1'b0;
      return v;
   endfunction

   // Full calibration as seen from the partner die. force_mask, when
   // non-zero, replaces the random failing lane pattern on failing codes.
   task automatic run_cal(input logic [15:0] pv, input logic [NL-1:0] force_mask,
                          input int early_end, output bit flow_ok, output bit order_ok,
                          output logic [3:0] start_msg, output logic [3:0] end_msg,
                          output bit ack_early);
      bit ok;
      flow_ok = 1'b1; order_ok = 1'b1; ack_early = 1'b0;
      start_msg = '0; end_msg = '0;
      i_en = 1'b1;
      tick();
      send_sb(4'b0001);
      wait_valid(20, ok);
      if (!ok) flow_ok = 1'b0;
      start_msg = o_sideband_message;
      pulse_busy();
      exp_q.delete();
      for (int k = 0; k < 16; k++) exp_q.push_back(VW'(k));
      for (int k = 0; k < 16; k++) begin
         if (!flow_ok) break;
         wait_pt_en(60, ok);
         if (!ok) begin flow_ok = 1'b0; break; end
         if (exp_q.size() == 0) order_ok = 1'b0;
         else if (o_reciever_ref_voltage !== exp_q.pop_front()) order_ok = 1'b0;
         // Noise: an end-request code with valid low must be ignored.
         i_decoded_sideband_message = 4'b0011;
         repeat ($urandom_range(0, 2)) tick();
         i_decoded_sideband_message = '0;
         i_pt_done = 1'b1;
         i_rx_lanes_result = pv[k] ? '1 : ((force_mask != '0) ? force_mask : fail_lanes());
         if (k == early_end) begin
            i_sideband_valid = 1'b1;
            i_decoded_sideband_message = 4'b0011;
         end
         tick();
         i_pt_done = 1'b0;
         i_rx_lanes_result = NL'($urandom);
         i_sideband_valid = 1'b0;
         i_decoded_sideband_message = '0;
      end
      if (exp_q.size() != 0) order_ok = 1'b0;
      if (flow_ok) begin
         if (early_end < 0) begin
            tick();
            send_sb(4'b0011);
         end
         wait_valid(30, ok);
         if (!ok) flow_ok = 1'b0;
         end_msg = o_sideband_message;
         ack_early = o_test_ack;
         pulse_busy();
         wait_ack(20, ok);
         if (!ok) flow_ok = 1'b0;
      end
   endtask

   // ---------------- reference model ----------------
   // Widest run of passing codes; the earliest run wins a tie.
   function automatic void model(input logic [15:0] pv, output int ev, output int ew,
                                 output int ef);
      int bl, bs, k, s;
      bl = 0; bs = 0; k = 0;
      while (k < 16) begin
         if (pv[k]) begin
            s = k;
            while (k < 16 && pv[k]) k++;
            if (k - s > bl) begin bl = k - s; bs = s; end
         end else begin
            k++;
         end
      end
      ew = bl;
      ef = (bl == 0) ? 1 : 0;
      ev = (bl > 0) ? bs + (bl - 1) / 2 : 8;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      tests_run++;
      if (o_reciever_ref_voltage !== 4'd8) begin tests_failed++;
         $display("FAIL reset_vref: got %0d exp 8", o_reciever_ref_voltage); end
      tests_run++;
      if ({o_valid_rx, o_pt_en, o_cal_fail, o_test_ack} !== 4'b0000) begin tests_failed++;
         $display("FAIL reset_flags: got %b exp 0000", {o_valid_rx, o_pt_en, o_cal_fail, o_test_ack}); end
      tests_run++;
      if (o_sideband_message !== 4'd0 || o_best_window !== 5'd0) begin tests_failed++;
         $display("FAIL reset_msg_win: got msg %b win %0d exp 0 0", o_sideband_message, o_best_window); end
      tests_run++;
      if (dbg_state !== ST_IDLE) begin tests_failed++;
         $display("FAIL reset_state: got %0d exp %0d", dbg_state, ST_IDLE); end
      rst_n = 1'b1;
      repeat (2) tick();
      tests_run++;
      if (dbg_state !== ST_IDLE || o_valid_rx !== 1'b0) begin tests_failed++;
         $display("FAIL idle_no_en: got state %0d valid %b exp 0 0", dbg_state, o_valid_rx); end
   endtask

   task automatic test_pattern(input string name, input logic [15:0] pv,
                               input logic [NL-1:0] force_mask, input int early_end,
                               input int ev, input int ew, input int ef);
      bit flow_ok, order_ok, ack_early;
      logic [3:0] smsg, emsg;
      run_cal(pv, force_mask, early_end, flow_ok, order_ok, smsg, emsg, ack_early);
      tests_run++;
      if (flow_ok !== 1'b1) begin tests_failed++;
         $display("FAIL %s flow: handshake/point-test timeout, got 0 exp 1", name); end
      tests_run++;
      if (order_ok !== 1'b1) begin tests_failed++;
         $display("FAIL %s sweep_order: codes not 0..15 in order, got 0 exp 1", name); end
      tests_run++;
      if (smsg !== 4'b0010 || emsg !== 4'b0100) begin tests_failed++;
         $display("FAIL %s sb_msgs: got %b/%b exp 0010/0100", name, smsg, emsg); end
      tests_run++;
      if (ack_early !== 1'b0 || o_test_ack !== 1'b1) begin tests_failed++;
         $display("FAIL %s ack: got early %b final %b exp 0 1", name, ack_early, o_test_ack); end
      tests_run++;
      if (o_reciever_ref_voltage !== VW'(ev)) begin tests_failed++;
         $display("FAIL %s vref: got %0d exp %0d", name, o_reciever_ref_voltage, ev); end
      tests_run++;
      if (o_best_window !== (VW+1)'(ew)) begin tests_failed++;
         $display("FAIL %s best_window: got %0d exp %0d", name, o_best_window, ew); end
      tests_run++;
      if (o_cal_fail !== 1'(ef)) begin tests_failed++;
         $display("FAIL %s cal_fail: got %b exp %0d", name, o_cal_fail, ef); end
      tests_run++;
      if (o_sideband_message !== 4'b0000) begin tests_failed++;
         $display("FAIL %s done_msg: got %b exp 0000", name, o_sideband_message); end
`ifdef VREF_SWEEP_LOG_EN
      tests_run++;
      if (o_pass_map !== pv) begin tests_failed++;
         $display("FAIL %s pass_map: got %h exp %h", name, o_pass_map, pv); end
`endif
      i_en = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_directed();
      test_pattern("win_5_11",   16'h0FE0, '0, -1, 8, 7, 0);
      test_pattern("two_win",    16'h7E1C, '0, -1, 11, 6, 0);
      test_pattern("tie_win",    16'h038E, '0, -1, 2, 3, 0);
      test_pattern("lane3_fail", 16'h0000, 16'hFFF7, -1, 8, 0, 1);
      test_pattern("all_pass",   16'hFFFF, '0, -1, 7, 16, 0);
      test_pattern("top_code",   16'h8000, '0, -1, 15, 1, 0);
   endtask

   task automatic test_early_end();
      test_pattern("early_end_6", 16'h0FE0, '0, 6, 8, 7, 0);
   endtask

   task automatic test_valid_tx_defer();
      bit ok;
      int early_hi;
      early_hi = 0;
      i_en = 1'b1;
      tick();
      i_valid_tx = 1'b1;
      send_sb(4'b0001);
      for (int c = 0; c < 4; c++) begin
         if (o_valid_rx !== 1'b0) early_hi++;
         tick();
      end
      tests_run++;
      if (early_hi != 0 || o_valid_rx !== 1'b0) begin tests_failed++;
         $display("FAIL vtx_defer: got %0d cycles of valid_rx while tx owns mux, exp 0", early_hi); end
      i_valid_tx = 1'b0;
      wait_valid(5, ok);
      tests_run++;
      if (ok !== 1'b1 || o_sideband_message !== 4'b0010) begin tests_failed++;
         $display("FAIL vtx_release: got rise %b msg %b exp 1 0010", ok, o_sideband_message); end
      pulse_busy();
      tests_run++;
      if (o_valid_rx !== 1'b0) begin tests_failed++;
         $display("FAIL vtx_busy_drop: got %b exp 0", o_valid_rx); end
      repeat (2) tick();
      tests_run++;
      if (o_valid_rx !== 1'b0) begin tests_failed++;
         $display("FAIL vtx_no_rearm: got %b exp 0", o_valid_rx); end
      i_en = 1'b0;
      tick();
      tests_run++;
      if (dbg_state !== ST_IDLE) begin tests_failed++;
         $display("FAIL vtx_abort_state: got %0d exp %0d", dbg_state, ST_IDLE); end
      tick();
   endtask

   task automatic test_abort();
      bit ok_v, ok_p;
      logic [15:0] pv;
      int ev, ew, ef;
      i_en = 1'b1;
      tick();
      send_sb(4'b0001);
      wait_valid(20, ok_v);
      // No busy pulse: the start response is still being requested.
      wait_pt_en(60, ok_p);
      tests_run++;
      if (ok_v !== 1'b1 || ok_p !== 1'b1 || o_valid_rx !== 1'b1) begin tests_failed++;
         $display("FAIL abort_setup: got valid %b pt_en %b exp 1 1", o_valid_rx, o_pt_en); end
      i_en = 1'b0;
      tick();
      tests_run++;
      if (o_pt_en !== 1'b0 || o_valid_rx !== 1'b0) begin tests_failed++;
         $display("FAIL abort_outputs: got pt_en %b valid %b exp 0 0", o_pt_en, o_valid_rx); end
      tests_run++;
      if (dbg_state !== ST_IDLE || o_reciever_ref_voltage !== 4'd0) begin tests_failed++;
         $display("FAIL abort_state_vref: got %0d/%0d exp %0d/0", dbg_state, o_reciever_ref_voltage, ST_IDLE); end
      repeat (2) tick();
      tests_run++;
      if (o_valid_rx !== 1'b0) begin tests_failed++;
         $display("FAIL abort_pending: got valid %b exp 0", o_valid_rx); end
      pv = 16'($urandom);
      model(pv, ev, ew, ef);
      test_pattern("restart", pv, '0, -1, ev, ew, ef);
   endtask

   task automatic test_random();
      logic [15:0] pv;
      int ev, ew, ef, early;
      for (int r = 0; r < 6; r++) begin
         case ($urandom_range(0, 2))
            0: pv = 16'($urandom);
            1: pv = 16'($urandom) & 16'($urandom);
            default: pv = 16'($urandom) | 16'($urandom);
         endcase
         early = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1;
         model(pv, ev, ew, ef);
         test_pattern("random", pv, '0, early, ev, ew, ef);
      end
   endtask

   task automatic test_reset_mid_sweep();
      bit ok;
      i_en = 1'b1;
      tick();
      send_sb(4'b0001);
      wait_valid(20, ok);
      pulse_busy();
      wait_pt_en(60, ok);
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if (o_reciever_ref_voltage !== 4'd8 || o_pt_en !== 1'b0 || dbg_state !== ST_IDLE) begin
         tests_failed++;
         $display("FAIL reset_mid: got vref %0d pt_en %b state %0d exp 8 0 %0d",
                  o_reciever_ref_voltage, o_pt_en, dbg_state, ST_IDLE);
      end
      i_en = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_directed();
      test_early_end();
      test_valid_tx_defer();
      test_abort();
      test_random();
      test_reset_mid_sweep();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Guards against a hung run: report and stop.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

endmodule
